// File: rtl/scan_pkg.sv
// Shared types for the nearest-vertex scan controller: FSM states and the
// "no candidate yet" distance value.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DIST_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/distance.sv
// Two-stage squared Euclidean distance between a query and a vertex position.
// Coordinates are signed 32-bit; the 32-bit result saturates at DIST_MAX.
module distance
    import scan_pkg::*;
#(
    parameter int DIM = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              data_valid_in,
    input  logic [32*DIM-1:0] vertex_pos_in,
    input  logic [32*DIM-1:0] query_pos_in,
    output logic              data_valid_out,
    output logic [31:0]       dist_out
);

    logic signed [32:0] r_diff [DIM];
    logic               r_valid1;
    logic               r_valid2;
    logic [31:0]        r_dist;
    logic [71:0]        w_acc;
    logic [31:0]        w_dist_sat;

    function automatic logic [65:0] square(input logic signed [32:0] x);
        logic signed [65:0] xe;
        xe = 66'(x);
        return xe * xe;
    endfunction

    always_comb begin
        w_acc = '0;
        for (int d = 0; d < DIM; d++) begin
            w_acc = w_acc + {6'b0, square(r_diff[d])};
        end
        w_dist_sat = (|w_acc[71:32]) ? DIST_MAX : w_acc[31:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
            r_dist   <= '0;
            for (int d = 0; d < DIM; d++) begin
                r_diff[d] <= '0;
            end
        end else begin
            r_valid1 <= data_valid_in;
            r_valid2 <= r_valid1;
            r_dist   <= w_dist_sat;
            for (int d = 0; d < DIM; d++) begin
                r_diff[d] <= $signed({query_pos_in[32*d+31], query_pos_in[32*d +: 32]})
                           - $signed({vertex_pos_in[32*d+31], vertex_pos_in[32*d +: 32]});
            end
        end
    end

    assign data_valid_out = r_valid2;
    assign dist_out       = r_dist;

endmodule

// File: rtl/nearest_scan_ctrl.sv
// Scans a contiguous (wrapping) range of vertex memory and reports the vertex
// closest to a query position together with its squared distance.
module nearest_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIM         = 1,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [32*DIM-1:0] query_pos_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [ADDR_W:0]   count_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_rd_out,
    input  logic [32*DIM-1:0] mem_data_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [31:0]       best_dist_out,
    output logic [ADDR_W-1:0] best_addr_out
);

    state_t                r_state;
    logic [32*DIM-1:0]     r_query;
    logic [ADDR_W-1:0]     r_base;
    logic [ADDR_W:0]       r_count;
    logic [ADDR_W:0]       r_issued;
    logic [ADDR_W:0]       r_results;
    logic [MEM_LATENCY-1:0] r_valid_pipe;
    logic [31:0]           r_best_dist;
    logic [ADDR_W-1:0]     r_best_addr;

    logic                  w_rd;
    logic [ADDR_W:0]       w_issued_next;
    logic [ADDR_W:0]       w_results_next;
    logic [MEM_LATENCY-1:0] w_pipe_next;
    logic                  w_dist_valid;
    logic [31:0]           w_dist;
    logic [ADDR_W-1:0]     w_result_addr;

    assign w_rd           = (r_state == SCAN);
    assign w_issued_next  = r_issued + (ADDR_W+1)'(1);
    assign w_results_next = r_results + {{ADDR_W{1'b0}}, w_dist_valid};
    assign w_result_addr  = r_base + r_results[ADDR_W-1:0];

    // The valid pipe mirrors the memory latency so each distance input lines up with its read.
    if (MEM_LATENCY == 1) begin : g_pipe1
        assign w_pipe_next = w_rd;
    end else begin : g_pipen
        assign w_pipe_next = {r_valid_pipe[MEM_LATENCY-2:0], w_rd};
    end

    distance #(.DIM(DIM)) u_distance (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_valid_in  (r_valid_pipe[MEM_LATENCY-1]),
        .vertex_pos_in  (mem_data_in),
        .query_pos_in   (r_query),
        .data_valid_out (w_dist_valid),
        .dist_out       (w_dist)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_query      <= '0;
            r_base       <= '0;
            r_count      <= '0;
            r_issued     <= '0;
            r_results    <= '0;
            r_valid_pipe <= '0;
            r_best_dist  <= DIST_MAX;
            r_best_addr  <= '0;
        end else begin
            r_valid_pipe <= w_pipe_next;

            // Strict less-than keeps the earliest address on ties.
            if (w_dist_valid && (r_state == SCAN || r_state == DRAIN)) begin
                r_results <= w_results_next;
                if (w_dist < r_best_dist) begin
                    r_best_dist <= w_dist;
                    r_best_addr <= w_result_addr;
                end
            end

            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_query     <= query_pos_in;
                        r_base      <= base_addr_in;
                        r_count     <= count_in;
                        r_issued    <= '0;
                        r_results   <= '0;
                        r_best_dist <= DIST_MAX;
                        r_best_addr <= base_addr_in;
                        r_state     <= (count_in == '0) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    r_issued <= w_issued_next;
                    if (w_issued_next == r_count) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_results_next == r_count) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd_out    = w_rd;
    assign mem_addr_out  = w_rd ? (r_base + r_issued[ADDR_W-1:0]) : '0;
    assign busy_out      = (r_state != IDLE);
    assign done_out      = (r_state == DONE);
    assign best_dist_out = r_best_dist;
    assign best_addr_out = r_best_addr;

endmodule

// File: tb/tb_nearest_scan_ctrl.sv
// Directed bench: three controllers (memory latency 2, 1 and 3) share one stimulus
// and one vertex memory; each gets its own read-latency model.
module tb_nearest_scan_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] queryPos;
    logic [3:0]  baseAddr;
    logic [4:0]  countIn;

    logic [3:0]  memAddrA, memAddrB, memAddrC;
    logic        memRdA, memRdB, memRdC;
    logic [31:0] memDataA, memDataB, memDataC;
    logic        busyA, busyB, busyC;
    logic        doneA, doneB, doneC;
    logic [31:0] bestDistA, bestDistB, bestDistC;
    logic [3:0]  bestAddrA, bestAddrB, bestAddrC;

    logic [31:0] mem [16];
    logic [31:0] d1Q, d2aQ, d2bQ, d3aQ, d3bQ, d3cQ;

    int compareCount = 0;
    int mismatchCount = 0;
    int cycle = 0;
    int readCountA = 0, readCountB = 0, readCountC = 0;
    int doneCountA = 0, doneCountB = 0, doneCountC = 0;
    int doneCycleA = 0;
    logic [3:0] readAddr [64];

    int readBaseA, readBaseB, readBaseC;
    int doneBaseA, doneBaseB, doneBaseC;
    int startCycle;
    logic busyAfterStart;

    nearest_scan_ctrl #(.DIM(1), .ADDR_W(4), .MEM_LATENCY(2)) dutA (
        .clk_in(clock), .rst_in(reset), .start_in(start), .query_pos_in(queryPos),
        .base_addr_in(baseAddr), .count_in(countIn), .mem_addr_out(memAddrA),
        .mem_rd_out(memRdA), .mem_data_in(memDataA), .busy_out(busyA),
        .done_out(doneA), .best_dist_out(bestDistA), .best_addr_out(bestAddrA)
    );

    nearest_scan_ctrl #(.DIM(1), .ADDR_W(4), .MEM_LATENCY(1)) dutB (
        .clk_in(clock), .rst_in(reset), .start_in(start), .query_pos_in(queryPos),
        .base_addr_in(baseAddr), .count_in(countIn), .mem_addr_out(memAddrB),
        .mem_rd_out(memRdB), .mem_data_in(memDataB), .busy_out(busyB),
        .done_out(doneB), .best_dist_out(bestDistB), .best_addr_out(bestAddrB)
    );

    nearest_scan_ctrl #(.DIM(1), .ADDR_W(4), .MEM_LATENCY(3)) dutC (
        .clk_in(clock), .rst_in(reset), .start_in(start), .query_pos_in(queryPos),
        .base_addr_in(baseAddr), .count_in(countIn), .mem_addr_out(memAddrC),
        .mem_rd_out(memRdC), .mem_data_in(memDataC), .busy_out(busyC),
        .done_out(doneC), .best_dist_out(bestDistC), .best_addr_out(bestAddrC)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory models: data for a read strobed in cycle t is presented in cycle t+latency.
    always @(posedge clock) begin
        d1Q  <= mem[memAddrB];
        d2aQ <= mem[memAddrA];
        d2bQ <= d2aQ;
        d3aQ <= mem[memAddrC];
        d3bQ <= d3aQ;
        d3cQ <= d3bQ;
    end
    assign memDataA = d2bQ;
    assign memDataB = d1Q;
    assign memDataC = d3cQ;

    // Monitor samples just after each rising edge and is the only writer of the counters.
    always @(posedge clock) begin
        #1;
        cycle++;
        if (memRdA) begin
            if (readCountA < 64) readAddr[readCountA] = memAddrA;
            readCountA++;
        end
        if (memRdB) readCountB++;
        if (memRdC) readCountC++;
        if (doneA) begin
            doneCycleA = cycle;
            doneCountA++;
        end
        if (doneB) doneCountB++;
        if (doneC) doneCountC++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // mode 0: plain scan, 1: stray start during SCAN, 2: reset during SCAN
    task automatic applyStimulus(input logic [31:0] q, input logic [3:0] b, input logic [4:0] n, input int mode);
        readBaseA = readCountA; readBaseB = readCountB; readBaseC = readCountC;
        doneBaseA = doneCountA; doneBaseB = doneCountB; doneBaseC = doneCountC;
        @(negedge clock);
        start = 1'b1; queryPos = q; baseAddr = b; countIn = n;
        startCycle = cycle;
        @(negedge clock);
        start = 1'b0;
        busyAfterStart = busyA;
        if (mode == 1) begin
            @(negedge clock);
            start = 1'b1; queryPos = 32'd0; baseAddr = 4'd7; countIn = 5'd2;
            @(negedge clock);
            start = 1'b0;
        end
        if (mode == 2) begin
            @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            repeat (20) @(negedge clock);
        end else begin
            for (int i = 0; i < 100; i++) begin
                if (doneCountA > doneBaseA && doneCountB > doneBaseB && doneCountC > doneBaseC) break;
                @(negedge clock);
            end
            checkOutput("done timeout", 32'((doneCountA > doneBaseA) && (doneCountB > doneBaseB) && (doneCountC > doneBaseC)), 32'd1);
            repeat (10) @(negedge clock);
        end
    endtask

    task automatic checkResults(input string tag, input logic [31:0] expDist, input logic [3:0] expAddr, input int expReads);
        checkOutput({tag, " distA"}, bestDistA, expDist);
        checkOutput({tag, " distB"}, bestDistB, expDist);
        checkOutput({tag, " distC"}, bestDistC, expDist);
        checkOutput({tag, " addrA"}, 32'(bestAddrA), 32'(expAddr));
        checkOutput({tag, " addrB"}, 32'(bestAddrB), 32'(expAddr));
        checkOutput({tag, " addrC"}, 32'(bestAddrC), 32'(expAddr));
        checkOutput({tag, " donesA"}, 32'(doneCountA - doneBaseA), 32'd1);
        checkOutput({tag, " donesB"}, 32'(doneCountB - doneBaseB), 32'd1);
        checkOutput({tag, " donesC"}, 32'(doneCountC - doneBaseC), 32'd1);
        checkOutput({tag, " readsA"}, 32'(readCountA - readBaseA), 32'(expReads));
        checkOutput({tag, " readsB"}, 32'(readCountB - readBaseB), 32'(expReads));
        checkOutput({tag, " readsC"}, 32'(readCountC - readBaseC), 32'(expReads));
        checkOutput({tag, " busyAfterStart"}, 32'(busyAfterStart), 32'd1);
        checkOutput({tag, " busyAfterDone"}, 32'(busyA), 32'd0);
    endtask

    task automatic checkAddrs(input string tag, input logic [3:0] expAddrs [4], input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s rdaddr%0d", tag, i), 32'(readAddr[readBaseA + i]), 32'(expAddrs[i]));
        end
    endtask

    logic [3:0] addrs0123 [4];
    logic [3:0] addrsWrap [4];
    logic [3:0] addrsTie  [4];

    initial begin
        addrs0123 = '{4'd0, 4'd1, 4'd2, 4'd3};
        addrsWrap = '{4'd14, 4'd15, 4'd0, 4'd1};
        addrsTie  = '{4'd5, 4'd6, 4'd0, 4'd0};
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        reset = 1'b1; start = 1'b0; queryPos = 32'd0; baseAddr = 4'd0; countIn = 5'd0;
        repeat (3) @(negedge clock);
        checkOutput("reset rd", 32'(memRdA), 32'd0);
        checkOutput("reset addr", 32'(memAddrA), 32'd0);
        checkOutput("reset busy", 32'(busyA), 32'd0);
        checkOutput("reset done", 32'(doneA), 32'd0);
        checkOutput("reset dist", bestDistA, 32'hFFFF_FFFF);
        checkOutput("reset bestaddr", 32'(bestAddrA), 32'd0);
        reset = 1'b0;

        $display("[TB] basic scan");
        mem[0] = 32'd13; mem[1] = 32'd7; mem[2] = 32'd12; mem[3] = 32'd9;
        applyStimulus(32'd10, 4'd0, 5'd4, 0);
        checkResults("basic", 32'd1, 4'd3, 4);
        checkAddrs("basic", addrs0123, 4);

        $display("[TB] tie");
        mem[5] = 32'd8; mem[6] = 32'd12;
        applyStimulus(32'd10, 4'd5, 5'd2, 0);
        checkResults("tie", 32'd4, 4'd5, 2);
        checkAddrs("tie", addrsTie, 2);

        $display("[TB] wrap");
        mem[14] = 32'd100; mem[15] = 32'd50; mem[0] = 32'd11; mem[1] = 32'd30;
        applyStimulus(32'd10, 4'd14, 5'd4, 0);
        checkResults("wrap", 32'd1, 4'd0, 4);
        checkAddrs("wrap", addrsWrap, 4);

        $display("[TB] zero count");
        applyStimulus(32'd10, 4'd9, 5'd0, 0);
        checkResults("zero", 32'hFFFF_FFFF, 4'd9, 0);
        checkOutput("zero donecycle", 32'(doneCycleA), 32'(startCycle + 1));

        $display("[TB] stray start");
        mem[0] = 32'd13; mem[1] = 32'd7; mem[2] = 32'd12; mem[3] = 32'd9;
        applyStimulus(32'd10, 4'd0, 5'd4, 1);
        checkResults("stray", 32'd1, 4'd3, 4);
        checkAddrs("stray", addrs0123, 4);

        $display("[TB] reset mid-scan");
        applyStimulus(32'd10, 4'd0, 5'd4, 2);
        checkOutput("abort donesA", 32'(doneCountA - doneBaseA), 32'd0);
        checkOutput("abort donesC", 32'(doneCountC - doneBaseC), 32'd0);
        checkOutput("abort busy", 32'(busyA), 32'd0);
        checkOutput("abort rd", 32'(memRdA), 32'd0);
        checkOutput("abort dist", bestDistA, 32'hFFFF_FFFF);
        checkOutput("abort bestaddr", 32'(bestAddrA), 32'd0);

        $display("[TB] scan after reset");
        applyStimulus(32'd10, 4'd0, 5'd4, 0);
        checkResults("recover", 32'd1, 4'd3, 4);
        checkAddrs("recover", addrs0123, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/nearest_scan_ctrl.md
NEAREST_SCAN_CTRL -- requirements
Module: nearest_scan_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 1: coordinates per position; position width is 32*DIM.
REQ-002 SHALL have parameter ADDR_W, default 10: vertex memory address width.
REQ-003 SHALL have parameter MEM_LATENCY, default 2: vertex memory read latency in cycles, 1 or more.
REQ-004 SHALL have port clk_in, input, 1: single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start_in, input, 1: begin a scan; sampled only in IDLE.
REQ-007 SHALL have port query_pos_in, input, 32*DIM: query position; latched on accepted start.
REQ-008 SHALL have port base_addr_in, input, ADDR_W: first vertex address; latched on accepted start.
REQ-009 SHALL have port count_in, input, ADDR_W+1: number of vertices to scan, 0 to 2^ADDR_W; latched on accepted start.
REQ-010 SHALL have port mem_addr_out, output, ADDR_W: vertex memory read address.
REQ-011 SHALL have port mem_rd_out, output, 1: read strobe, one read per asserted cycle.
REQ-012 SHALL have port mem_data_in, input, 32*DIM: read data, valid MEM_LATENCY cycles after its strobe.
REQ-013 SHALL have port busy_out, output, 1: high from the cycle after an accepted start until the DONE cycle, inclusive.
REQ-014 SHALL have port done_out, output, 1: single-cycle completion pulse.
REQ-015 SHALL have port best_dist_out, output, 32: minimum squared distance found.
REQ-016 SHALL have port best_addr_out, output, ADDR_W: address of the minimum.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-018 IDLE, start_in=1, count_in>0: latch the inputs, clear the issue and result counters, set best_dist to 32'hFFFF_FFFF, and go to SCAN.
REQ-019 IDLE, start_in=1, count_in=0: go directly to DONE; best_dist_out=32'hFFFF_FFFF and best_addr_out=base_addr_in.
REQ-020 SCAN: assert mem_rd_out every cycle with mem_addr_out=base+issued, modulo 2^ADDR_W (wraps past the top address); after count reads, go to DRAIN.
REQ-021 SHALL delay mem_rd_out through a MEM_LATENCY-deep valid shift register; its output drives the distance data_valid_in, with vertex_pos_in=mem_data_in and query_pos_in=the latched query.
REQ-022 Each distance data_valid_out SHALL increment the result counter k; results arrive in issue order, so result k belongs to address base+k (mod 2^ADDR_W).
REQ-023 Update best only when the result is strictly less than best; ties keep the earliest address.
REQ-024 DRAIN: when the result counter reaches count, go to DONE; a final result arriving in the transition cycle SHALL still be compared.
REQ-025 DONE: done_out=1 for one cycle; best_dist_out and best_addr_out SHALL be valid in that cycle and held until the next accepted start.
REQ-026 start_in outside IDLE SHALL be ignored; it is neither queued nor allowed to alter the latched inputs.
REQ-027 Counters SHALL be ADDR_W+1 bits so that count=2^ADDR_W completes without overflow.

Reset
REQ-028 When rst_in=1, the block SHALL enter IDLE on the next edge and zero all counters and the valid pipeline.
REQ-029 Reset output values SHALL be: mem_rd_out=0, mem_addr_out=0, busy_out=0, done_out=0, best_dist_out=32'hFFFF_FFFF, best_addr_out=0.
REQ-030 Reset mid-scan SHALL discard in-flight reads and results; no done_out is produced for the aborted scan.
REQ-031 The distance instance SHALL share rst_in, so its pipeline is flushed by the same reset.

Structure
REQ-032 Package scan_pkg SHALL hold the state enum (IDLE, SCAN, DRAIN, DONE) and DIST_MAX=32'hFFFF_FFFF.
REQ-033 SHALL instantiate exactly one sub-module, distance #(.DIM(DIM)); no other datapath multipliers.
REQ-034 Completion SHALL be detected by result count, never by a hard-coded distance-pipeline latency.

Verification
REQ-035 DIM=1, query=10, mem[0..3]={13,7,12,9}, base=0, count=4 -> exactly 4 reads at addresses 0..3, one done_out pulse, best_dist=1, best_addr=3.
REQ-036 Tie: query=10, mem={8,12}, count=2 -> best_dist=4, best_addr=base (first of the two).
REQ-037 Wrap: ADDR_W=4, base=14, count=4 -> addresses 14,15,0,1 issued; best_addr correct across the wrap.
REQ-038 count=0 -> done_out on the cycle after start, best_dist=32'hFFFF_FFFF, mem_rd_out never asserted.
REQ-039 start_in pulsed during SCAN with different inputs -> no effect on addresses or result; rst_in mid-SCAN -> IDLE, no done_out, and a clean new scan completes correctly afterward.
REQ-040 MEM_LATENCY=1 and MEM_LATENCY=3 with the REQ-035 stimulus -> identical best_dist and best_addr.
